// File: rtl/slr_sched_pkg.sv
// Shared types and constants for the two-requester shift scheduler.
package slr_sched_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  typedef logic req_id_t;
endpackage

// File: rtl/slr_rr_arb.sv
// Two-way arbiter: round robin by default, fixed priority (requester 0 first)
// when SLR_SCHED_FIXED_PRIO_EN is defined.
module slr_rr_arb
  import slr_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  output logic [NUM_REQ-1:0] grant
);
`ifdef SLR_SCHED_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, upd};
  always_comb grant = req[0] ? 2'b01 : req;
`else
  req_id_t last;
  // last=1 after reset so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst)
    if (rst)      last <= 1'b1;
    else if (upd) last <= grant[1];
  always_comb grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
`endif
endmodule

// File: rtl/slr_sched.sv
// Arbitrated multi-cycle logical right shifter; step per cycle is at most
// 2**amt_n-1. Arbitration mode selected by SLR_SCHED_FIXED_PRIO_EN.
module slr_sched
  import slr_sched_pkg::*;
#(
  parameter int n     = 8,
  parameter int amt_n = 3,
  parameter int tot_n = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [n-1:0]       req_d0,
  input  logic [n-1:0]       req_d1,
  input  logic [tot_n-1:0]   req_amt0,
  input  logic [tot_n-1:0]   req_amt1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [n-1:0]       rsp_data,
  output logic               rsp_id
);
  localparam int S  = (1 << amt_n) - 1;
  localparam int RW = $clog2(n + 1);

  state_t             state, nxt;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [n-1:0]       data;
  logic [RW-1:0]      rem, step, amt_c;
  logic [tot_n-1:0]   amt_sel;
  req_id_t            id;

  slr_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .upd   (accept),
    .grant (grant)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign amt_sel   = grant[1] ? req_amt1 : req_amt0;

  // Amounts beyond the data width all yield zero, so clamp to n
  always_comb begin
    amt_c = (int'(amt_sel) >= n) ? RW'(n) : RW'(amt_sel);
    step  = (int'(rem) > S) ? RW'(S) : rem;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (amt_c == '0) ? RESP : SHIFT;
      SHIFT:   if (rem == step) nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data <= '0;
      rem  <= '0;
      id   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          data <= grant[1] ? req_d1 : req_d0;
          rem  <= amt_c;
          id   <= grant[1];
        end
        SHIFT: begin
          data <= data >> step;
          rem  <= rem - step;
        end
        default: ;
      endcase
    end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = data;
  assign rsp_id    = id;
endmodule

// File: tb/tb_slr_sched.sv
// Randomized + directed bench for slr_sched against a transaction-level model.
module tb_slr_sched;
  localparam int N = 8;
  localparam int S = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [7:0] req_d0 = '0, req_d1 = '0;
  logic [3:0] req_amt0 = '0, req_amt1 = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_id;

  int n_chk = 0, n_err = 0;

  typedef enum {P_IDLE, P_WAIT, P_RESP} ph_t;
  ph_t        ph = P_IDLE;
  int         k = 0;
  logic       last = 1'b1;
  logic [1:0] pend = '0;
  logic [7:0] pd [2];
  logic [3:0] pa [2];
  logic [7:0] exp_data = '0;
  logic       exp_id = 1'b0;

  slr_sched u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_d0    (req_d0),
    .req_d1    (req_d1),
    .req_amt0  (req_amt0),
    .req_amt1  (req_amt1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Winner among pending requesters under the configured policy
  function automatic logic [1:0] mgrant(input logic [1:0] p);
`ifdef SLR_SCHED_FIXED_PRIO_EN
    if (p[0]) return 2'b01;
    return p;
`else
    if (p == 2'b11) return (last == 1'b1) ? 2'b01 : 2'b10;
    return p;
`endif
  endfunction

  // One clock of stimulus, model update and checking; entered and left at negedge
  task automatic tick();
    logic [1:0] acc;
    int a, idx;
    acc = '0;
    req_valid = pend;
    req_d0 = pd[0]; req_amt0 = pa[0];
    req_d1 = pd[1]; req_amt1 = pa[1];
    #1;
    chk("req_ready", req_ready, (ph == P_IDLE) ? mgrant(pend) : 2'b00);
    case (ph)
      P_IDLE: if (pend != 0) begin
        acc = mgrant(pend);
        idx = acc[1] ? 1 : 0;
        a = (int'(pa[idx]) >= N) ? N : int'(pa[idx]);
        exp_data = pd[idx] >> a;
        exp_id = acc[1];
        last = acc[1];
        k = (a + S - 1) / S;
        ph = (k == 0) ? P_RESP : P_WAIT;
      end
      P_WAIT: begin
        k--;
        if (k == 0) ph = P_RESP;
      end
      P_RESP: if (rsp_ready) ph = P_IDLE;
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
    pend &= ~acc;
    req_valid = pend;
    if (ph == P_RESP) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_id", rsp_id, exp_id);
    end else
      chk("rsp_valid", rsp_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    pend = '0;
    req_valid = '0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_req_ready", req_ready, 0);
    ph = P_IDLE;
    last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Run from acceptance to retirement, checking result and latency literally
  task automatic serve(input logic [7:0] ed, input logic eid, input int elat, input string tag);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cnt++;
      if (rsp_valid) seen = 1;
    end
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_id"}, rsp_id, eid);
    chk({tag, "_lat"}, cnt - 1, elat);
    if (seen) tick();
  endtask

  initial begin
    pd[0] = '0; pd[1] = '0; pa[0] = '0; pa[1] = '0;
    do_reset();
    rsp_ready = 1'b1;

    pend[0] = 1; pd[0] = 8'b1011_0110; pa[0] = 4'd3;
    serve(8'b0001_0110, 1'b0, 1, "amt3");
    pend[1] = 1; pd[1] = 8'hFF; pa[1] = 4'd10;
    serve(8'h00, 1'b1, 2, "amt10");
    pend[0] = 1; pd[0] = 8'hA5; pa[0] = 4'd0;
    serve(8'hA5, 1'b0, 0, "amt0");

    do_reset();
    pend = 2'b11; pd[0] = 8'h80; pa[0] = 4'd7; pd[1] = 8'h80; pa[1] = 4'd1;
    serve(8'h01, 1'b0, 1, "tie0");
`ifdef SLR_SCHED_FIXED_PRIO_EN
    pend[0] = 1;
    serve(8'h01, 1'b0, 1, "prio0");
`endif
    serve(8'h40, 1'b1, 1, "tie1");

    // Back-pressure while another requester waits
    rsp_ready = 1'b0;
    pend = 2'b11; pd[0] = 8'h3C; pa[0] = 4'd2; pd[1] = 8'hF0; pa[1] = 4'd4;
    for (int i = 0; i < 10 && ph != P_RESP; i++) tick();
    chk("hold_reached", ph == P_RESP, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", rsp_data, 8'h0F);
      chk("hold_id", rsp_id, 0);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    serve(8'h0F, 1'b1, 1, "drain1");

    // Reset in the middle of a shift abandons it
    pend[0] = 1; pd[0] = 8'hFF; pa[0] = 4'd14;
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    pend = 2'b11; pd[0] = 8'hC3; pa[0] = 4'd5; pd[1] = 8'h11; pa[1] = 4'd1;
    serve(8'h06, 1'b0, 1, "post_rst0");
    serve(8'h08, 1'b1, 1, "post_rst1");

    for (int i = 0; i < 2500; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pd[r] = 8'($urandom);
          pa[r] = 4'($urandom_range(0, 15));
        end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (i % 800 == 799) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
